// File: rtl/tile_pkg.sv
// Shared widths, tile encoding and ROM address helper for the tile ROM arbiter.
package tile_pkg;

   localparam int unsigned TILE_W = 1;
   localparam int unsigned ROW_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = TILE_W + ROW_W;

   typedef enum logic [TILE_W-1:0] {
      TILE_WALL  = 1'b0,
      TILE_FLOOR = 1'b1
   } tile_e;

   // ROM rows are laid out tile-major: all rows of tile 0, then all rows of tile 1.
   function automatic logic [ADDR_W-1:0] rom_addr_of(input logic [TILE_W-1:0] tile,
                                                     input logic [ROW_W-1:0]  row);
      return {tile, row};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 3,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   // One extra bit so ptr + offset cannot overflow before the modulo fold.
   logic [IDX_W:0]   cand_w;
   logic [IDX_W-1:0] cand;

   // Scan NUM_REQ candidates starting at ptr_i; the first hit wins.
   always_comb begin
      gnt_o  = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      cand_w = '0;
      cand   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand_w = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
            cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
         end
         cand = cand_w[IDX_W-1:0];
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Round-robin arbiter sharing one combinational tile ROM between NUM_REQ requesters.
// Two-stage pipeline: grant + address register, then ROM sample + pixel extract.
module tile_rom_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned TILE_W  = tile_pkg::TILE_W,
   parameter int unsigned ROW_W   = tile_pkg::ROW_W,
   parameter int unsigned DATA_W  = tile_pkg::DATA_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ*TILE_W-1:0]  tile_sel_i,
   input  logic [NUM_REQ*ROW_W-1:0]   row_i,
   input  logic [NUM_REQ*ROW_W-1:0]   col_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [NUM_REQ-1:0]         rvalid_o,
   output logic [DATA_W-1:0]          rdata_o,
   output logic                       rpixel_o,
   output logic [TILE_W+ROW_W-1:0]    rom_addr_o,
   input  logic [DATA_W-1:0]          rom_data_i
);
   import tile_pkg::*;

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned AW    = TILE_W + ROW_W;

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]      rom_addr_q, rom_addr_d;
   logic               s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]   s1_id_q, s1_id_d;
   logic [ROW_W-1:0]   s1_col_q, s1_col_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               rpixel_q, rpixel_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [DATA_W-1:0]  rom_rev;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_i (req_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Grant is suppressed while reset is held so no requester sees a phantom handshake.
   assign gnt_o = rst_i ? '0 : pick_gnt;

   // Stage 1: advance pointer past the winner and capture its address and column.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rom_addr_d = rom_addr_q;
      s1_valid_d = 1'b0;
      s1_id_d    = s1_id_q;
      s1_col_d   = s1_col_q;
      if (pick_any) begin
         rr_ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         rom_addr_d = {tile_sel_i[pick_idx*TILE_W +: TILE_W], row_i[pick_idx*ROW_W +: ROW_W]};
         s1_valid_d = 1'b1;
         s1_id_d    = pick_idx;
         s1_col_d   = col_i[pick_idx*ROW_W +: ROW_W];
      end
   end

   // Column 0 is the MSB of the row, so index a bit-reversed copy.
   always_comb begin
      rom_rev = '0;
      for (int unsigned k = 0; k < DATA_W; k++) begin
         rom_rev[k] = rom_data_i[DATA_W-1-k];
      end
   end

   // Stage 2: sample ROM output; data and pixel hold when no response is issued.
   always_comb begin
      rvalid_d = '0;
      rdata_d  = rdata_q;
      rpixel_d = rpixel_q;
      if (s1_valid_q) begin
         rvalid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << s1_id_q;
         rdata_d  = rom_data_i;
         rpixel_d = rom_rev[s1_col_q];
      end
   end

   // Pipeline state; reset drops anything in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         rom_addr_q <= '0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_col_q   <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
         rpixel_q   <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rom_addr_q <= rom_addr_d;
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s1_col_q   <= s1_col_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rpixel_q   <= rpixel_d;
      end
   end

   assign rom_addr_o = rom_addr_q;
   assign rvalid_o   = rvalid_q;
   assign rdata_o    = rdata_q;
   assign rpixel_o   = rpixel_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Scoreboard bench for tile_rom_arbiter: a reference model predicts grants and responses,
// a separate monitor pops expectations whenever the DUT strobes rvalid.
module tb_tile_rom_arbiter;
   import tile_pkg::*;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = TILE_W + ROW_W;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        pix;
      int          due;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N-1:0]       req = '0;
   logic [N*TILE_W-1:0] tile_sel = '0;
   logic [N*ROW_W-1:0] row = '0;
   logic [N*ROW_W-1:0] col = '0;
   logic [N-1:0]       gnt, rvalid;
   logic [DATA_W-1:0]  rdata, rom_data;
   logic               rpixel;
   logic [AW-1:0]      rom_addr;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          model_ptr = 0;
   logic [N-1:0] last_gnt = '0;
   logic [AW-1:0] exp_addr = '0;
   logic [31:0] last_data = '0;
   logic        last_pix  = 1'b0;
   exp_t        q[$];

   always #5 clk = ~clk;

   // Tile bitmaps: wall is a frame, floor has a few fixed rows then a hashed pattern.
   function automatic logic [31:0] rom_row(input logic [AW-1:0] a);
      int r;
      r = int'(a[ROW_W-1:0]);
      if (a[AW-1] == 1'b0) begin
         return (r == 0 || r == 31) ? 32'hFFFF_FFFF : 32'h8000_0001;
      end
      case (r)
         0:       return 32'h0000_0000;
         1:       return 32'h07F8_1FE0;
         2:       return 32'h1FFF_FFF8;
         default: return 32'h9E37_79B9 ^ (32'h0101_0101 * 32'(r));
      endcase
   endfunction

   assign rom_data = rom_row(rom_addr);

   tile_rom_arbiter #(
      .NUM_REQ (N),
      .TILE_W  (TILE_W),
      .ROW_W   (ROW_W),
      .DATA_W  (DATA_W)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .tile_sel_i (tile_sel),
      .row_i      (row),
      .col_i      (col),
      .gnt_o      (gnt),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata),
      .rpixel_o   (rpixel),
      .rom_addr_o (rom_addr),
      .rom_data_i (rom_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: round-robin scan from the model pointer, predict the response.
   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic [AW-1:0] a;
      logic [ROW_W-1:0] c;
      logic [31:0] d;
      int w;
      eg = '0;
      w  = -1;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (model_ptr + k) % N;
            if (w < 0 && req[j]) w = j;
         end
      end
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", gnt, eg);
      if (w >= 0) begin
         a = rom_addr_of(tile_sel[w*TILE_W +: TILE_W], row[w*ROW_W +: ROW_W]);
         c = col[w*ROW_W +: ROW_W];
         d = rom_row(a);
         q.push_back('{id: w, data: d, pix: d[31 - int'(c)], due: cyc + 2});
         exp_addr  = a;
         model_ptr = (w + 1) % N;
      end
      if (rst) begin
         q.delete();
         model_ptr = 0;
         exp_addr  = '0;
         last_data = '0;
         last_pix  = 1'b0;
      end
      last_gnt = gnt;
   end

   // Monitor: pops one expectation per rvalid strobe, checks hold behaviour otherwise.
   always @(posedge clk) begin
      exp_t e;
      logic [N-1:0] erv;
      #1;
      chk("rom_addr", rom_addr, exp_addr);
      if (rvalid !== '0) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_unexpected: got %b required 0 (cycle %0d)", rvalid, cyc);
         end else begin
            e = q.pop_front();
            erv = '0;
            erv[e.id] = 1'b1;
            chk("rvalid", rvalid, erv);
            chk("rdata", rdata, e.data);
            chk("rpixel", rpixel, e.pix);
            chk("latency", cyc, e.due);
            last_data = e.data;
            last_pix  = e.pix;
         end
      end else begin
         chk("rdata_hold", rdata, last_data);
         chk("rpixel_hold", rpixel, last_pix);
         if (q.size() > 0 && q[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_missing: got 0 required id %0d (cycle %0d)", q[0].id, cyc);
            q.delete(0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input logic [TILE_W-1:0] t,
                          input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] c);
      req[i] = 1'b1;
      tile_sel[i*TILE_W +: TILE_W] = t;
      row[i*ROW_W +: ROW_W] = r;
      col[i*ROW_W +: ROW_W] = c;
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;

      // Single requester 0, wall row 1, columns 0 and 1.
      set_req(0, TILE_WALL, 5'd1, 5'd0); tick(); req = '0; repeat (3) tick();
      set_req(0, TILE_WALL, 5'd1, 5'd1); tick(); req = '0; repeat (3) tick();
      // Single requester 1, floor row 1, columns 5 and 0.
      set_req(1, TILE_FLOOR, 5'd1, 5'd5); tick(); req = '0; repeat (3) tick();
      set_req(1, TILE_FLOOR, 5'd1, 5'd0); tick(); req = '0; repeat (3) tick();

      // All three held for nine cycles straight out of reset.
      rst = 1'b1; tick(); rst = 1'b0;
      set_req(0, TILE_WALL, 5'd31, 5'd3);
      set_req(1, TILE_FLOOR, 5'd0, 5'd7);
      set_req(2, TILE_FLOOR, 5'd2, 5'd2);
      repeat (9) tick();
      req = '0; repeat (3) tick();

      // Pointer at 2 with req = 011: 0 wins, then 1.
      set_req(1, TILE_FLOOR, 5'd4, 5'd9); tick(); req = '0;
      set_req(0, TILE_WALL, 5'd6, 5'd0);
      set_req(1, TILE_FLOOR, 5'd2, 5'd3);
      repeat (2) tick();
      req = '0; repeat (3) tick();

      // Reset in the cycle after a grant discards it; pointer restarts at 0.
      set_req(0, TILE_WALL, 5'd0, 5'd4); tick(); req = '0;
      rst = 1'b1; tick(); rst = 1'b0;
      set_req(0, TILE_WALL, 5'd2, 5'd31);
      set_req(1, TILE_FLOOR, 5'd3, 5'd1);
      set_req(2, TILE_FLOOR, 5'd5, 5'd2);
      tick(); req = '0; repeat (3) tick();

      // Bring pointer to 0, then pulse req[1] alongside winning req[0].
      set_req(2, TILE_FLOOR, 5'd7, 5'd7); tick(); req = '0;
      set_req(0, TILE_WALL, 5'd9, 5'd0);
      set_req(1, TILE_FLOOR, 5'd1, 5'd5);
      tick(); req = '0; repeat (3) tick();

      // Randomized traffic with legal early drops, re-requests and occasional resets.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (last_gnt[i] || !req[i]) begin
               if ($urandom_range(0, 2) != 0) begin
                  set_req(i, TILE_W'($urandom), ROW_W'($urandom), ROW_W'($urandom));
               end else begin
                  req[i] = 1'b0;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req[i] = 1'b0;
            end
         end
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end

      rst = 1'b0;
      req = '0;
      repeat (4) tick();
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
